// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
//  Shared definitions for the NoC router datapath.
//  - Flit geometry: DATAW-bit flit = {type[TYPEW-1:0], payload[PAYLOADW-1:0]},
//    with the type field in the MSBs.
//  - Virtual-channel id width and crossbar select width.
//  - Flit type codes and input port indices used by the crossbar output mux.
// -----------------------------------------------------------------------------
package noc_pkg;

   localparam int DATAW    = 67;
   localparam int VCHW     = 1;
   localparam int SELW     = 5;
   localparam int TYPEW    = 3;
   localparam int PAYLOADW = DATAW - TYPEW;

   // Flit type codes carried in the top TYPEW bits of every flit.
   typedef enum logic [TYPEW-1:0] {
      TYPE_NONE = 3'h0,
      TYPE_HEAD = 3'h1,
      TYPE_DATA = 3'h2,
      TYPE_TAIL = 3'h3
   } flit_type_e;

   // Input port indices; also the bit positions of the one-hot grant.
   localparam int PORT_0 = 0;
   localparam int PORT_1 = 1;

   // Assemble a flit from its type code and payload.
   function automatic logic [DATAW-1:0] make_flit(input flit_type_e   ftype,
                                                  input logic [PAYLOADW-1:0] payload);
      return {ftype, payload};
   endfunction

endpackage : noc_pkg

// File: rtl/mux_2to1.sv
// -----------------------------------------------------------------------------
// mux_2to1
//  Two-input flit multiplexer for the router crossbar output stage. A one-hot
//  grant picks one input port; its {data, valid, vch} bundle is forwarded as a
//  unit to the single output. Flit contents pass through uninterpreted.
//
//  Parameters
//   DATAW   flit width ({type, payload}, type in the MSBs)
//   VCHW    virtual-channel id width
//   SELW    select width (router port count); only sel[1:0] is decoded
//   REG_OUT 1 = registered output (1-cycle latency), 0 = combinational
//
//  Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   idata_0   in   flit from input port 0
//   ivalid_0  in   flit valid, port 0
//   ivch_0    in   VC id, port 0
//   idata_1   in   flit from input port 1
//   ivalid_1  in   flit valid, port 1
//   ivch_1    in   VC id, port 1
//   sel       in   one-hot grant: sel[0] -> port 0, sel[1] -> port 1
//   odata     out  selected flit
//   ovalid    out  selected valid
//   ovch      out  selected VC id
//   sel_err   out  sticky: sel[1:0] == 2'b11 observed since reset
// -----------------------------------------------------------------------------
module mux_2to1 #(
   parameter int DATAW   = noc_pkg::DATAW,
   parameter int VCHW    = noc_pkg::VCHW,
   parameter int SELW    = noc_pkg::SELW,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DATAW-1:0] idata_0,
   input  logic             ivalid_0,
   input  logic [VCHW-1:0]  ivch_0,
   input  logic [DATAW-1:0] idata_1,
   input  logic             ivalid_1,
   input  logic [VCHW-1:0]  ivch_1,
   input  logic [SELW-1:0]  sel,
   output logic [DATAW-1:0] odata,
   output logic             ovalid,
   output logic [VCHW-1:0]  ovch,
   output logic             sel_err
);

   import noc_pkg::*;

   // Only the two grant bits for this mux are decoded.
   logic [1:0] grant;
   assign grant = sel[1:0];

   // Upper grant bits belong to other crossbar columns and are ignored here.
   generate
      if (SELW > 2) begin : g_sel_hi
         logic unused_sel_hi;
         assign unused_sel_hi = ^sel[SELW-1:2];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Combinational select. A double grant is resolved in favour of port 0 so the
   // output always carries one coherent bundle; the fault is flagged separately.
   // ---------------------------------------------------------------------------
   logic [DATAW-1:0] mux_data;
   logic             mux_valid;
   logic [VCHW-1:0]  mux_vch;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path through
      // the if/else leaves a variable unassigned and no latch is inferred.
      mux_data  = '0;
      mux_valid = 1'b0;
      mux_vch   = '0;
      if (grant[PORT_0]) begin
         mux_data  = idata_0;
         mux_valid = ivalid_0;
         mux_vch   = ivch_0;
      end else if (grant[PORT_1]) begin
         mux_data  = idata_1;
         mux_valid = ivalid_1;
         mux_vch   = ivch_1;
      end
   end

   // ---------------------------------------------------------------------------
   // Output stage: registered (1-cycle latency) or straight pass-through.
   // ---------------------------------------------------------------------------
   generate
      if (REG_OUT) begin : g_reg_out
         always_ff @(posedge clk or posedge rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (rst) begin
               odata  <= '0;
               ovalid <= 1'b0;
               ovch   <= '0;
            end else begin
               odata  <= mux_data;
               ovalid <= mux_valid;
               ovch   <= mux_vch;
            end
         end
      end else begin : g_comb_out
         assign odata  = mux_data;
         assign ovalid = mux_valid;
         assign ovch   = mux_vch;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Sticky double-grant flag; always registered, cleared only by reset.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err <= 1'b0;
      end else if (grant == 2'b11) begin
         sel_err <= 1'b1;
      end
   end

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1
//  Directed bench for mux_2to1 with the default (registered) configuration.
//  Inputs are driven 1 time unit after each rising edge; outputs are sampled at
//  the same point, i.e. they reflect what was selected at the preceding edge.
// -----------------------------------------------------------------------------
module tb_mux_2to1;

   import noc_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [DATAW-1:0] idata_0 = '0;
   logic             ivalid_0 = 1'b0;
   logic [VCHW-1:0]  ivch_0 = '0;
   logic [DATAW-1:0] idata_1 = '0;
   logic             ivalid_1 = 1'b0;
   logic [VCHW-1:0]  ivch_1 = '0;
   logic [SELW-1:0]  sel = '0;
   logic [DATAW-1:0] odata;
   logic             ovalid;
   logic [VCHW-1:0]  ovch;
   logic             sel_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mux_2to1 dut (
      .clk      (clk),
      .rst      (rst),
      .idata_0  (idata_0),
      .ivalid_0 (ivalid_0),
      .ivch_0   (ivch_0),
      .idata_1  (idata_1),
      .ivalid_1 (ivalid_1),
      .ivch_1   (ivch_1),
      .sel      (sel),
      .odata    (odata),
      .ovalid   (ovalid),
      .ovch     (ovch),
      .sel_err  (sel_err)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATAW-1:0] rand_flit();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[DATAW-1:0];
   endfunction

   task automatic randomize_inputs();
      idata_0  = rand_flit();
      idata_1  = rand_flit();
      ivalid_0 = 1'($urandom_range(0, 1));
      ivalid_1 = 1'($urandom_range(0, 1));
      ivch_0   = VCHW'($urandom_range(0, 1));
      ivch_1   = VCHW'($urandom_range(0, 1));
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_odata"},   128'(odata),   128'(0));
      check({tag, "_ovalid"},  128'(ovalid),  128'(0));
      check({tag, "_ovch"},    128'(ovch),    128'(0));
      check({tag, "_sel_err"}, 128'(sel_err), 128'(0));
   endtask

   // Packet flit for the streaming test: sequence number in the payload.
   function automatic logic [DATAW-1:0] pkt_flit(input int p, input int f);
      logic [PAYLOADW-1:0] seq;
      seq = PAYLOADW'(p * 22 + f);
      if (f == 0)       return make_flit(TYPE_HEAD, seq);
      else if (f == 21) return make_flit(TYPE_TAIL, seq);
      else              return make_flit(TYPE_DATA, seq);
   endfunction

   logic [DATAW-1:0] stream [22];
   logic [DATAW-1:0] flit_a, flit_b, flit_c;
   logic [63:0]      one64;
   int               valid_cnt, rises, falls, exp_idx;
   logic             prev_valid;

   initial begin
      // ---- 1. reset with random inputs, before and across clock edges ------
      randomize_inputs();
      sel = 5'b00001;
      #1 rst = 1'b1;
      #1 check_cleared("rst_async");
      for (int i = 0; i < 3; i++) begin
         randomize_inputs();
         sel = SELW'($urandom_range(0, 31));
         tick();
         check_cleared("rst_held");
      end

      // ---- 2. port-1 packet: HEAD, 20 walking DATA, TAIL --------------------
      one64 = 64'h1;
      stream[0] = make_flit(TYPE_HEAD, {32'h0, 32'h4});
      for (int i = 0; i < 20; i++)
         stream[i+1] = make_flit(TYPE_DATA, (i % 2 == 0) ? (one64 << i) : ~(one64 << i));
      stream[21] = make_flit(TYPE_TAIL, 64'hDEAD_BEEF_0000_0021);

      rst      = 1'b0;
      sel      = 5'b00010;
      ivalid_1 = 1'b1;
      ivch_1   = 1'b0;
      for (int k = 0; k < 22; k++) begin
         idata_1  = stream[k];
         idata_0  = rand_flit();
         ivalid_0 = 1'($urandom_range(0, 1));
         ivch_0   = 1'($urandom_range(0, 1));
         tick();
         check("p1_odata",  128'(odata),  128'(stream[k]));
         check("p1_ovalid", 128'(ovalid), 128'(1));
         check("p1_ovch",   128'(ovch),   128'(0));
      end
      check("p1_sel_err", 128'(sel_err), 128'(0));

      // ---- 3. port-0 HEAD on VC 1 --------------------------------------------
      sel      = 5'b00001;
      idata_0  = make_flit(TYPE_HEAD, {32'h0, 32'h9});
      ivalid_0 = 1'b1;
      ivch_0   = 1'b1;
      tick();
      check("p0_odata",  128'(odata),  128'(67'h1_0000_0000_0000_0009));
      check("p0_ovch",   128'(ovch),   128'(1));
      check("p0_ovalid", 128'(ovalid), 128'(1));

      // ---- 4. no grant while both inputs are valid ---------------------------
      sel      = 5'b00000;
      ivalid_0 = 1'b1;
      ivalid_1 = 1'b1;
      ivch_1   = 1'b1;
      tick();
      check("idle_ovalid", 128'(ovalid), 128'(0));
      check("idle_odata",  128'(odata),  128'(0));
      check("idle_ovch",   128'(ovch),   128'(0));

      // Upper select bits are ignored.
      flit_b  = make_flit(TYPE_DATA, 64'h0123_4567_89AB_CDEF);
      idata_1 = flit_b;
      sel     = 5'b11110;
      tick();
      check("hi_sel_odata",   128'(odata),   128'(flit_b));
      check("hi_sel_ovch",    128'(ovch),    128'(1));
      check("hi_sel_sel_err", 128'(sel_err), 128'(0));
      sel = 5'b11100;
      tick();
      check("hi_idle_ovalid", 128'(ovalid), 128'(0));

      // ---- 5. double grant: port 0 wins, sticky error -----------------------
      flit_a  = make_flit(TYPE_TAIL, 64'hA5A5_5A5A_F00D_CAFE);
      idata_0 = flit_a;
      ivch_0  = 1'b0;
      sel     = 5'b00011;
      tick();
      check("dbl_odata",   128'(odata),   128'(flit_a));
      check("dbl_ovch",    128'(ovch),    128'(0));
      check("dbl_sel_err", 128'(sel_err), 128'(1));
      sel = 5'b00010;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sticky_odata",   128'(odata),   128'(flit_b));
         check("sticky_sel_err", 128'(sel_err), 128'(1));
      end

      // Reset mid-packet clears outputs before the next edge.
      #2 rst = 1'b1;
      #1 check_cleared("rst_mid");
      tick();
      check_cleared("rst_mid_held");
      rst      = 1'b0;
      flit_c   = make_flit(TYPE_HEAD, 64'h0000_0000_0000_0077);
      idata_0  = flit_c;
      ivalid_0 = 1'b1;
      sel      = 5'b00001;
      tick();
      check("post_rst_odata",  128'(odata),  128'(flit_c));
      check("post_rst_ovalid", 128'(ovalid), 128'(1));

      // ---- 6. ten 22-flit packets with 7-cycle gaps on port 1 ----------------
      sel      = 5'b00010;
      ivalid_1 = 1'b0;
      tick();
      check("pre_stream_ovalid", 128'(ovalid), 128'(0));
      valid_cnt  = 0;
      rises      = 0;
      falls      = 0;
      exp_idx    = 0;
      prev_valid = ovalid;
      for (int p = 0; p < 10; p++) begin
         for (int c = 0; c < 29; c++) begin
            if (c < 22) begin
               idata_1  = pkt_flit(p, c);
               ivalid_1 = 1'b1;
            end else begin
               idata_1  = rand_flit();
               ivalid_1 = 1'b0;
            end
            ivch_1  = 1'(p);
            idata_0 = rand_flit();
            tick();
            check("stream_ovalid", 128'(ovalid), 128'(c < 22));
            if (ovalid) begin
               check("stream_odata", 128'(odata), 128'(pkt_flit(exp_idx / 22, exp_idx % 22)));
               valid_cnt++;
               exp_idx++;
            end
            if (ovalid && !prev_valid) rises++;
            if (!ovalid && prev_valid) falls++;
            prev_valid = ovalid;
         end
      end
      check("stream_valid_cnt", 128'(valid_cnt), 128'(220));
      check("stream_rises",     128'(rises),     128'(10));
      check("stream_falls",     128'(falls),     128'(10));
      check("stream_sel_err",   128'(sel_err),   128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mux_2to1
